accum_64bit: RTL and testbench
==============================

ACCUM_64BIT -- requirements
Module: accum_64bit

Interface
REQ-001 Parameter BURST_LEN, default 4, number of operands summed per result; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  pulse; begins a new burst when sampled in IDLE.
REQ-005 abort  input  1  synchronous; discards the current burst.
REQ-006 in_valid  input  1  operand present on in_data.
REQ-007 in_data  input  64  unsigned operand.
REQ-008 in_ready  output  1  block accepts an operand this cycle.
REQ-009 out_valid  output  1  result present on out_sum/out_ovf.
REQ-010 out_sum  output  64  accumulated sum.
REQ-011 out_ovf  output  1  sticky unsigned overflow (adder carry-out) seen during the burst.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 busy  output  1  high in ACCUM or DONE.

Function
REQ-014 FSM states: IDLE, ACCUM, DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 -> ACCUM, clear acc, cnt and ovf to 0.
REQ-016 ACCUM: in_ready=1; transfer occurs when in_valid and in_ready are both 1.
REQ-017 On transfer: acc <= acc + in_data via 64-bit carry-lookahead add, cin=0; ovf <= ovf | carry-out; cnt <= cnt+1.
REQ-018 Transfer with cnt==BURST_LEN-1 -> DONE next cycle; the result is valid the cycle after the last transfer (latency 1).
REQ-019 in_valid=0 in ACCUM: no state change; arbitrary stall length allowed.
REQ-020 DONE: in_ready=0, out_valid=1; out_sum=acc, out_ovf=ovf held stable until out_ready=1.
REQ-021 DONE with out_ready=1 -> IDLE next cycle; out_valid drops the same edge.
REQ-022 start while in ACCUM or DONE is ignored.
REQ-023 abort=1 in any state -> IDLE next cycle, acc/cnt/ovf cleared, no result issued; abort has priority over start, transfer and out_ready.
REQ-024 start and out_ready in the same DONE cycle: return to IDLE only; start is not queued.
REQ-025 Sum wraps modulo 2^64 unless REQ-029 applies.

Reset
REQ-026 rst_n low asynchronously forces IDLE, acc=0, cnt=0, ovf=0, in_ready=0, out_valid=0, busy=0, out_sum=0, out_ovf=0.
REQ-027 Reset mid-burst discards all partial state; the first start after release begins a fresh burst.

Configuration
REQ-028 Macro ACCUM_SAT_EN selects overflow handling.
REQ-029 ACCUM_SAT_EN defined: on any carry-out, acc becomes 64'hFFFF_FFFF_FFFF_FFFF and stays there for the rest of the burst; ovf is still set.
REQ-030 ACCUM_SAT_EN undefined: acc wraps (REQ-025); ovf is set on carry-out; no saturation logic present.

Structure
REQ-031 Package accum_pkg holds the state enum, the BURST_LEN default, and the count width constant CNT_W=8.
REQ-032 One sub-module: CLA_64bit performs the add (a=acc, b=in_data, cin=0, cout feeds ovf); no other adder is present.

Verification
REQ-033 Directed scenario: BURST_LEN=4; start; operands 1,2,3,4 on consecutive cycles -> out_valid one cycle after the 4th, out_sum=10, out_ovf=0.
REQ-034 Directed scenario: in_valid gaps of 3 cycles between operands 5,5,5,5 -> out_sum=20; in_ready stays 1 throughout ACCUM.
REQ-035 Directed scenario: operands FFFF_FFFF_FFFF_FFFF,2,0,0 -> out_ovf=1; out_sum=1 without ACCUM_SAT_EN, all-ones with it.
REQ-036 Directed scenario: out_ready held 0 for 5 cycles in DONE -> out_valid and out_sum stable; out_ready=1 -> IDLE next cycle.
REQ-037 Directed scenario: abort after 2 transfers -> IDLE and no out_valid; next burst 7,7,7,7 -> out_sum=28.
REQ-038 Directed scenario: rst_n asserted mid-ACCUM, off-edge -> all outputs 0 immediately; start after release gives correct fresh sum.

Source files
------------

// File: rtl/accum_pkg.sv
// accum_pkg: shared state encoding and sizing constants for accum_64bit.
//   BURST_LEN_DEF : default operands per burst
//   CNT_W         : width of the operand counter
package accum_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int BURST_LEN_DEF = 4;
  localparam int CNT_W = 8;
endpackage

// File: rtl/accum_64bit_cla.sv
// CLA_64bit: 64-bit carry-lookahead adder built from 4-bit lookahead groups.
//   a, b : addends
//   cin  : carry-in
//   sum  : a + b + cin (mod 2^64)
//   cout : carry-out of bit 63
module CLA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  logic [63:0] g, p;
  logic [64:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  // Each group derives all four internal carries and its carry-out
  // directly from its carry-in, so no carry ripples inside a group.
  for (genvar i = 0; i < 16; i++) begin : grp
    localparam int B = 4 * i;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end
  assign sum  = p ^ c[63:0];
  assign cout = c[64];
endmodule

// File: rtl/accum_64bit.sv
// accum_64bit: sums BURST_LEN 64-bit operands per burst with sticky carry-out flag.
//   clk, rst_n          : clock, async active-low reset
//   start, abort        : begin burst (from IDLE), discard burst (any state)
//   in_valid/in_ready   : operand handshake, in_data operand
//   out_valid/out_ready : result handshake, out_sum / out_ovf result
//   busy                : high in ACCUM or DONE
// Build option: define ACCUM_SAT_EN to saturate the sum to all-ones on carry-out.
module accum_64bit
  import accum_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_sum,
  output logic        out_ovf,
  input  logic        out_ready,
  output logic        busy
);
  state_t state;
  logic [63:0] acc, sum, acc_nx;
  logic [CNT_W-1:0] cnt;
  logic ovf, cout, xfer;
  CLA_64bit u_cla (.a(acc), .b(in_data), .cin(1'b0), .sum(sum), .cout(cout));
`ifdef ACCUM_SAT_EN
  // Once a carry has been seen the sum is pinned at all-ones for the burst.
  assign acc_nx = (cout | ovf) ? '1 : sum;
`else
  assign acc_nx = sum;
`endif
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign xfer      = in_ready & in_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          acc   <= '0;
          cnt   <= '0;
          ovf   <= 1'b0;
        end
        ACCUM: if (xfer) begin
          acc   <= acc_nx;
          ovf   <= ovf | cout;
          cnt   <= cnt + 1'b1;
          state <= cnt == CNT_W'(BURST_LEN - 1) ? DONE : ACCUM;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accum_64bit.sv
// tb_accum_64bit: directed scoreboard bench for accum_64bit (BURST_LEN=4).
module tb_accum_64bit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic in_ready, out_valid, out_ovf, busy;
  logic [63:0] out_sum;
  int n_tests = 0, n_fail = 0;
  logic [64:0] sb[$];

  accum_64bit #(.BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model result is queued when the burst is driven, popped at result time.
  task automatic burst(input logic [63:0] o0, o1, o2, o3,
                       input int gap, input int hold, input bit with_start);
    logic [63:0] ops[4];
    logic [64:0] t, e;
    logic [63:0] a;
    logic v;
    ops = '{o0, o1, o2, o3};
    a = '0;
    v = 1'b0;
    foreach (ops[i]) begin
      t = {1'b0, a} + {1'b0, ops[i]};
      v = v | t[64];
      a = t[63:0];
`ifdef ACCUM_SAT_EN
      if (v) a = '1;
`endif
    end
    sb.push_back({v, a});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_accum", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        check("ready_stall", 64'(in_ready), 64'd1);
      end
      check("no_early_valid", 64'(out_valid), 64'd0);
      check("ready_accum", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data = ops[i];
      start = (i == 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("valid_latency", 64'(out_valid), 64'd1);
    check("ready_done", 64'(in_ready), 64'd0);
    e = sb.pop_front();
    check("sum", out_sum, e[63:0]);
    check("ovf", 64'(out_ovf), 64'(e[64]));
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_sum", out_sum, e[63:0]);
    end
    out_ready = 1'b1;
    start = with_start;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("done_exit_valid", 64'(out_valid), 64'd0);
    check("done_exit_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("no_restart", 64'(busy), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sum"}, out_sum, 64'd0);
    check({tag, "_ovf"}, 64'(out_ovf), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    burst(64'd1, 64'd2, 64'd3, 64'd4, 0, 0, 1'b0);
    burst(64'd5, 64'd5, 64'd5, 64'd5, 3, 0, 1'b0);
    burst(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0, 0, 0, 1'b0);
    burst(64'h8000_0000_0000_0000, 64'h1234, 64'h8000_0000_0000_0000, 64'd1, 1, 5, 1'b1);
    // abort after two transfers, with an operand offered in the abort cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 64'd100;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    check_idle("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    burst(64'd7, 64'd7, 64'd7, 64'd7, 0, 0, 1'b0);
    // asynchronous reset mid-burst, away from any clock edge
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 64'd50;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    burst(64'd3, 64'd4, 64'd5, 64'd6, 0, 1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
